// File: rtl/ibert_stage_sequencer_if.sv
// Stage-engine bus: descriptor fields and launch pulse out to the stage tops,
// plus their completion and error pulses back in.
interface ibert_stage_sequencer_if #(
  parameter int ADDR_W = 64
);
  logic              stg_start;
  logic [ADDR_W-1:0] stg_addr_A;
  logic [ADDR_W-1:0] stg_addr_K;
  logic [ADDR_W-1:0] stg_addr_G;
  logic [31:0]       stg_m_mult;
  logic [7:0]        stg_e_mult;
  logic [31:0]       stg_m_G;
  logic [7:0]        stg_e_G;
  logic              stg_done;
  logic              stg_error;

  modport master (
    output stg_start, stg_addr_A, stg_addr_K, stg_addr_G,
           stg_m_mult, stg_e_mult, stg_m_G, stg_e_G,
    input  stg_done, stg_error
  );

  modport slave (
    input  stg_start, stg_addr_A, stg_addr_K, stg_addr_G,
           stg_m_mult, stg_e_mult, stg_m_G, stg_e_G,
    output stg_done, stg_error
  );
endinterface

// File: rtl/ibert_stage_sequencer.sv
// Walks a descriptor table of encoder stages, launching each in turn, for a
// programmable number of layers, with per-stage watchdog and fault capture.
module ibert_stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 64,
  parameter int TIMEOUT_W  = 32,
  parameter int SIDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [SIDX_W-1:0]    cfg_stage,
  input  logic [2:0]           cfg_field,
  input  logic [63:0]          cfg_wdata,
  input  logic [7:0]           num_layers,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [SIDX_W-1:0]    err_stage,
  output logic [SIDX_W-1:0]    cur_stage,
  output logic [7:0]           cur_layer,
  output logic [31:0]          cycle_count,
  ibert_stage_sequencer_if.master stg
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_g;
    logic [31:0]       m_mult;
    logic [7:0]        e_mult;
    logic [31:0]       m_g;
    logic [7:0]        e_g;
  } desc_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, LAUNCH, WAIT, NEXT, FINISH, FAULT
  } state_t;

  desc_t                tbl [NUM_STAGES];
  state_t               state;
  logic [7:0]           layers;
  logic [TIMEOUT_W-1:0] tmo;
  logic [TIMEOUT_W-1:0] wd;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic                 cnt_en;
  logic                 last_stage;

  assign wd_inc     = wd + TIMEOUT_W'(1);
  assign last_stage = (32'(cur_stage) == NUM_STAGES - 1);

  // The very first LOAD of a run precedes the counting window; later LOADs sit inside it.
  assign cnt_en = (state inside {LAUNCH, WAIT, NEXT, FINISH, FAULT}) ||
                  (state == LOAD && (cur_stage != '0 || cur_layer != 8'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) tbl[i] <= '0;
    end else if (cfg_we && !busy && 32'(cfg_stage) < NUM_STAGES) begin
      case (cfg_field)
        3'd0:    tbl[cfg_stage].addr_a <= cfg_wdata[ADDR_W-1:0];
        3'd1:    tbl[cfg_stage].addr_k <= cfg_wdata[ADDR_W-1:0];
        3'd2:    tbl[cfg_stage].addr_g <= cfg_wdata[ADDR_W-1:0];
        3'd3:    tbl[cfg_stage].m_mult <= cfg_wdata[31:0];
        3'd4:    tbl[cfg_stage].e_mult <= cfg_wdata[7:0];
        3'd5:    tbl[cfg_stage].m_g    <= cfg_wdata[31:0];
        3'd6:    tbl[cfg_stage].e_g    <= cfg_wdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      layers         <= 8'd1;
      tmo            <= '0;
      wd             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
      err_stage      <= '0;
      cur_stage      <= '0;
      cur_layer      <= 8'd0;
      cycle_count    <= 32'd0;
      stg.stg_start  <= 1'b0;
      stg.stg_addr_A <= '0;
      stg.stg_addr_K <= '0;
      stg.stg_addr_G <= '0;
      stg.stg_m_mult <= 32'd0;
      stg.stg_e_mult <= 8'd0;
      stg.stg_m_G    <= 32'd0;
      stg.stg_e_G    <= 8'd0;
    end else begin
      stg.stg_start <= 1'b0;
      if (cnt_en && cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;

      case (state)
        IDLE: if (start) begin
          layers      <= (num_layers == 8'd0) ? 8'd1 : num_layers;
          tmo         <= timeout_cycles;
          done        <= 1'b0;
          error       <= 1'b0;
          err_code    <= 2'd0;
          err_stage   <= '0;
          cycle_count <= 32'd0;
          cur_stage   <= '0;
          cur_layer   <= 8'd0;
          busy        <= 1'b1;
          state       <= LOAD;
        end
        LOAD: begin
          stg.stg_addr_A <= tbl[cur_stage].addr_a;
          stg.stg_addr_K <= tbl[cur_stage].addr_k;
          stg.stg_addr_G <= tbl[cur_stage].addr_g;
          stg.stg_m_mult <= tbl[cur_stage].m_mult;
          stg.stg_e_mult <= tbl[cur_stage].e_mult;
          stg.stg_m_G    <= tbl[cur_stage].m_g;
          stg.stg_e_G    <= tbl[cur_stage].e_g;
          stg.stg_start  <= 1'b1;
          state          <= LAUNCH;
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT;
        end
        // Error beats done; done beats a watchdog expiring in the same cycle.
        WAIT: begin
          if (stg.stg_error) begin
            error     <= 1'b1;
            err_code  <= 2'd1;
            err_stage <= cur_stage;
            busy      <= 1'b0;
            state     <= FAULT;
          end else if (stg.stg_done) begin
            state <= NEXT;
          end else if (tmo != '0 && wd_inc == tmo) begin
            error     <= 1'b1;
            err_code  <= 2'd2;
            err_stage <= cur_stage;
            busy      <= 1'b0;
            state     <= FAULT;
          end else begin
            wd <= wd_inc;
          end
        end
        NEXT: begin
          if (!last_stage) begin
            cur_stage <= cur_stage + SIDX_W'(1);
            state     <= LOAD;
          end else if (cur_layer != layers - 8'd1) begin
            cur_stage <= '0;
            cur_layer <= cur_layer + 8'd1;
            state     <= LOAD;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibert_stage_sequencer.sv
// Randomised bench: each run is planned as an event schedule (launch/response
// times), and every output is checked each cycle against that schedule.
module tb_ibert_stage_sequencer;
  localparam int NS = 3;
  localparam int K_DONE = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_stage;
  logic [2:0]  cfg_field;
  logic [63:0] cfg_wdata;
  logic [7:0]  num_layers;
  logic [31:0] timeout_cycles;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  err_code, err_stage, cur_stage;
  logic [7:0]  cur_layer;
  logic [31:0] cycle_count;

  ibert_stage_sequencer_if #(.ADDR_W(64)) sif ();

  ibert_stage_sequencer #(.NUM_STAGES(NS), .ADDR_W(64), .TIMEOUT_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .num_layers(num_layers),
    .timeout_cycles(timeout_cycles), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_stage(err_stage),
    .cur_stage(cur_stage), .cur_layer(cur_layer), .cycle_count(cycle_count),
    .stg(sif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  // descriptor table model
  logic [63:0] m_a [NS], m_k [NS], m_g [NS];
  logic [31:0] m_mm [NS], m_mg [NS];
  logic [7:0]  m_em [NS], m_eg [NS];

  // run plan: per-launch kind/delay in, schedule out
  int kind_q [64], dly_q [64];
  int L [64], R [64], st [64], ly [64];
  int nl, t_end, e_code, e_stg, ts, chk_end;
  bit faulted, active = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NS; i++) begin
      m_a[i] = 0; m_k[i] = 0; m_g[i] = 0; m_mm[i] = 0; m_mg[i] = 0; m_em[i] = 0; m_eg[i] = 0;
    end
  endtask

  task automatic cfg_write(input int s, input int f, input logic [63:0] d);
    @(posedge clk); #1;
    cfg_we = 1; cfg_stage = 2'(s); cfg_field = 3'(f); cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 0;
    if (s < NS) case (f)
      0: m_a[s] = d;
      1: m_k[s] = d;
      2: m_g[s] = d;
      3: m_mm[s] = d[31:0];
      4: m_em[s] = d[7:0];
      5: m_mg[s] = d[31:0];
      6: m_eg[s] = d[7:0];
      default: ;
    endcase
  endtask

  // Schedule from the latency rules: first launch 2 cycles after start,
  // next launch 3 after a done, done flag 2 after the last done, fault flag
  // 1 after the error or after the timeout_cycles-th WAIT cycle.
  task automatic build(input int layers, input int tmo);
    int lay, t;
    lay = (layers == 0) ? 1 : layers;
    t = 2; nl = 0; faulted = 0; e_code = 0; e_stg = 0; t_end = 0;
    for (int k = 0; k < lay * NS; k++) begin
      L[k] = t; st[k] = k % NS; ly[k] = k / NS; R[k] = t + dly_q[k]; nl = k + 1;
      if (kind_q[k] == K_ERR || kind_q[k] == K_BOTH) begin
        if (!(tmo != 0 && dly_q[k] > tmo)) begin
          faulted = 1; e_code = 1; e_stg = st[k]; t_end = R[k] + 1; break;
        end
      end
      if (tmo != 0 && (kind_q[k] == K_NONE || dly_q[k] > tmo)) begin
        faulted = 1; e_code = 2; e_stg = st[k]; t_end = t + tmo + 1; R[k] = -100; break;
      end
      if (k == lay * NS - 1) t_end = R[k] + 2;
      else t = R[k] + 3;
    end
  endtask

  task automatic run(input int layers, input int tmo, input bit noise, input int rst_at);
    build(layers, tmo);
    @(posedge clk); #1;
    ts = cyc;
    chk_end = (rst_at >= 0) ? rst_at : t_end + 3;
    active = 1;
    num_layers = 8'(layers); timeout_cycles = tmo;
    for (int rel = 0; rel <= chk_end; rel++) begin
      if (rel > 0) begin @(posedge clk); #1; end
      start = (rel == 0) || (noise && rel <= t_end && $urandom_range(0, 3) == 0);
      sif.stg_done = 0; sif.stg_error = 0; cfg_we = 0;
      for (int k = 0; k < nl; k++) begin
        if (R[k] == rel) begin
          sif.stg_done  = (kind_q[k] != K_ERR);
          sif.stg_error = (kind_q[k] == K_ERR || kind_q[k] == K_BOTH);
        end
        if (noise && L[k] == rel)     sif.stg_done  |= 1'($urandom_range(0, 1));
        if (noise && L[k] - 1 == rel) sif.stg_error |= 1'($urandom_range(0, 1));
      end
      if (noise && rel >= 1) begin
        num_layers = 8'($urandom_range(0, 255));
        timeout_cycles = $urandom_range(0, 20);
        if (rel < t_end && $urandom_range(0, 2) == 0) begin
          cfg_we = 1; cfg_stage = 2'($urandom); cfg_field = 3'($urandom);
          cfg_wdata = {$urandom, $urandom};
        end
      end
      rst = (rel == rst_at);
    end
    @(posedge clk); #1;
    active = 0; start = 0; sif.stg_done = 0; sif.stg_error = 0; cfg_we = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_err_stage"}, err_stage, 0);
    chk({tag, "_cur_stage"}, cur_stage, 0);
    chk({tag, "_cur_layer"}, cur_layer, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
    chk({tag, "_stg_start"}, sif.stg_start, 0);
    chk({tag, "_addr_A"}, sif.stg_addr_A, 0);
    chk({tag, "_m_mult"}, sif.stg_m_mult, 0);
    chk({tag, "_e_G"}, sif.stg_e_G, 0);
  endtask

  // per-cycle compare against the schedule
  always @(negedge clk) begin
    int rel, kc, kd, cc;
    bit es;
    if (active) begin
      rel = cyc - ts;
      if (rel >= 1 && rel <= chk_end) begin
        es = 0; kc = 0; kd = -1;
        for (int k = 0; k < nl; k++) begin
          if (L[k] == rel) es = 1;
          if (L[k] - 1 <= rel) kc = k;
          if (L[k] <= rel) kd = k;
        end
        cc = rel - L[0];
        if (cc < 0) cc = 0;
        if (cc > t_end - L[0] + 1) cc = t_end - L[0] + 1;
        chk("stg_start", sif.stg_start, es);
        chk("cur_stage", cur_stage, st[kc]);
        chk("cur_layer", cur_layer, ly[kc]);
        chk("busy", busy, rel < t_end);
        chk("done", done, rel >= t_end && !faulted);
        chk("error", error, rel >= t_end && faulted);
        chk("err_code", err_code, (rel >= t_end) ? e_code : 0);
        chk("err_stage", err_stage, (rel >= t_end) ? e_stg : 0);
        chk("cycle_count", cycle_count, cc);
        if (kd >= 0) begin
          chk("addr_A", sif.stg_addr_A, m_a[st[kd]]);
          chk("addr_K", sif.stg_addr_K, m_k[st[kd]]);
          chk("addr_G", sif.stg_addr_G, m_g[st[kd]]);
          chk("m_mult", sif.stg_m_mult, m_mm[st[kd]]);
          chk("e_mult", sif.stg_e_mult, m_em[st[kd]]);
          chk("m_G", sif.stg_m_G, m_mg[st[kd]]);
          chk("e_G", sif.stg_e_G, m_eg[st[kd]]);
        end
      end
    end
  end

  task automatic plan_all(input int kind, input int dly);
    for (int k = 0; k < 64; k++) begin kind_q[k] = kind; dly_q[k] = dly; end
  endtask

  initial begin
    int tmo, r;
    rst = 1; cfg_we = 0; cfg_stage = 0; cfg_field = 0; cfg_wdata = 0;
    num_layers = 0; timeout_cycles = 0; start = 0;
    sif.stg_done = 0; sif.stg_error = 0;
    mdl_clear();
    repeat (3) @(posedge clk);
    #1; rst = 0;
    chk_zero("reset");

    for (int s = 0; s < NS; s++) begin
      cfg_write(s, 0, 64'h1000 * (s + 1));
      for (int f = 1; f < 7; f++) cfg_write(s, f, {$urandom, $urandom});
    end
    cfg_write(3, 0, 64'hDEAD);
    cfg_write(1, 7, 64'hBEEF);

    // three stages, one layer, done 10 cycles after each launch
    plan_all(K_DONE, 10);
    run(1, 0, 0, -1);
    chk("pin_L0", L[0], 2);
    chk("pin_L2", L[2], 28);
    chk("pin_tend", t_end, 40);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_cycle_count", cycle_count, 39);
    chk("t1_last_addr_A", sif.stg_addr_A, 64'h3000);

    // two layers
    run(2, 0, 0, -1);
    chk("pin_nl", nl, 6);
    chk("pin_ly3", ly[3], 1);
    chk("t2_done", done, 1);
    chk("t2_cur_layer", cur_layer, 1);

    // stage error on stage 1
    plan_all(K_DONE, 10); kind_q[1] = K_ERR;
    run(1, 0, 0, -1);
    chk("t3_err_code", err_code, 1);
    chk("t3_err_stage", err_stage, 1);
    chk("t3_busy", busy, 0);

    // watchdog, no response
    plan_all(K_NONE, 1);
    run(1, 5, 0, -1);
    chk("pin_tmo_tend", t_end, 8);
    chk("t4_err_code", err_code, 2);
    chk("t4_cycle_count", cycle_count, 7);

    // done+error together, with start/cfg noise while busy
    plan_all(K_DONE, 6); kind_q[2] = K_BOTH;
    run(1, 0, 1, -1);
    chk("t5_err_code", err_code, 1);
    chk("t5_err_stage", err_stage, 2);

    // randomised runs
    for (int it = 0; it < 14; it++) begin
      tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 10);
      for (int k = 0; k < 64; k++) begin
        r = $urandom_range(0, 19);
        kind_q[k] = (r == 0) ? K_ERR : (r == 1) ? K_BOTH : (r == 2 && tmo != 0) ? K_NONE : K_DONE;
        dly_q[k] = $urandom_range(1, (tmo != 0) ? tmo + 2 : 12);
      end
      run($urandom_range(0, 3), tmo, 1, -1);
      repeat ($urandom_range(0, 2)) cfg_write($urandom_range(0, 3), $urandom_range(0, 7), {$urandom, $urandom});
    end

    // reset in WAIT of stage 1
    plan_all(K_DONE, 10);
    build(1, 0);
    r = L[1] + 3;
    run(1, 0, 0, r);
    rst = 0;
    mdl_clear();
    chk_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_start", sif.stg_start, 0);
    end
    for (int k = 0; k < 64; k++) dly_q[k] = $urandom_range(1, 8);
    run(1, 0, 0, -1);
    chk("post_rst_addr_A", sif.stg_addr_A, 0);
    chk("post_rst_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
